// File: rtl/fb_pkg.sv
// Shared types and constants for the triple-buffered RGB565 frame store scheduler.
package fb_pkg;

  localparam int FRAME_WORDS = 19200;

  typedef logic [1:0] bank_t;

  // Base addresses for the default frame size; the top rescales from its own parameter.
  localparam int BASE0 = 0;
  localparam int BASE1 = FRAME_WORDS;
  localparam int BASE2 = 2 * FRAME_WORDS;

  typedef enum logic {
    IDLE    = 1'b0,
    WRITING = 1'b1
  } wr_state_e;

endpackage

// File: rtl/fb_sat_counter.sv
// Saturating event counter with asynchronous active-low clear.
module fb_sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc_i,
  output logic [W-1:0] count_o
);

  logic [W-1:0] count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (inc_i && (count_q != '1)) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/fb_bank_scheduler.sv
// Triple-buffer bank scheduler: camera writer FSM, frame-boundary display swap, BRAM addressing.
// Optional statistics counters (drop_cnt, repeat_cnt) are built only when FB_STATS_EN is defined.
module fb_bank_scheduler #(
  parameter int FRAME_WORDS = fb_pkg::FRAME_WORDS,
  parameter int AW          = 16,
  parameter int CNT_W       = 8
) (
  input  logic             CLK_25M,
  input  logic             RESETN,
  input  logic             cam_frame_start,
  input  logic             cam_frame_done,
  input  logic             cam_pix_valid,
  input  logic [15:0]      cam_pix_data,
  input  logic [AW-1:0]    disp_addr,
  input  logic             disp_frame_end,
  output logic             wea,
  output logic [AW-1:0]    addra,
  output logic [15:0]      dina,
  output logic [AW-1:0]    addrb,
  output logic [1:0]       rd_bank,
  output logic [1:0]       wr_bank,
  output logic             wr_ovf,
  output logic [CNT_W-1:0] drop_cnt,
  output logic [CNT_W-1:0] repeat_cnt
);

  import fb_pkg::*;

  localparam logic [AW-1:0] BASE_1    = AW'(FRAME_WORDS);
  localparam logic [AW-1:0] BASE_2    = AW'(2 * FRAME_WORDS);
  localparam logic [AW-1:0] FRAME_END = AW'(FRAME_WORDS);

  function automatic logic [AW-1:0] bank_base(input bank_t b);
    case (b)
      2'd1:    return BASE_1;
      2'd2:    return BASE_2;
      default: return '0;
    endcase
  endfunction

  wr_state_e     state_q;
  bank_t         wr_bank_q, rd_bank_q, ready_bank_q;
  logic          ready_valid_q;
  logic [AW-1:0] wr_cnt_q;
  logic          wea_q, wr_ovf_q, disp_end_q;
  logic [AW-1:0] addra_q;
  logic [15:0]   dina_q;

  logic  disp_rise, commit;
  bank_t free_bank_d;

  assign disp_rise = disp_frame_end & ~disp_end_q;
  assign commit    = (state_q == WRITING) & cam_frame_done;

  // The new write bank must avoid both the displayed bank and a pending ready frame.
  always_comb begin
    // NOTE: default first so every path assigns free_bank_d and no latch is inferred.
    free_bank_d = 2'd2;
    if ((rd_bank_q != 2'd0) && !(ready_valid_q && (ready_bank_q == 2'd0))) begin
      free_bank_d = 2'd0;
    end else if ((rd_bank_q != 2'd1) && !(ready_valid_q && (ready_bank_q == 2'd1))) begin
      free_bank_d = 2'd1;
    end
  end

  // NOTE: async reset covers every state register here; there is no memory array to leave unreset.
  always_ff @(posedge CLK_25M or negedge RESETN) begin
    if (!RESETN) begin
      state_q       <= IDLE;
      wr_bank_q     <= 2'd1;
      rd_bank_q     <= 2'd0;
      ready_bank_q  <= 2'd0;
      ready_valid_q <= 1'b0;
      wr_cnt_q      <= '0;
      wea_q         <= 1'b0;
      addra_q       <= '0;
      dina_q        <= '0;
      wr_ovf_q      <= 1'b0;
      disp_end_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking throughout, so the defaults below are overridden cleanly later in the block.
      disp_end_q <= disp_frame_end;
      wea_q      <= 1'b0;

      unique case (state_q)
        IDLE: begin
          if (cam_frame_start) begin
            state_q   <= WRITING;
            wr_cnt_q  <= '0;
            wr_ovf_q  <= 1'b0;
            wr_bank_q <= free_bank_d;
          end
        end
        WRITING: begin
          if (cam_frame_start && !cam_frame_done) begin
            // Aborted frame: rewrite the same bank from the top.
            wr_cnt_q <= '0;
            wr_ovf_q <= 1'b0;
          end else begin
            if (cam_pix_valid) begin
              if (wr_cnt_q < FRAME_END) begin
                wea_q    <= 1'b1;
                addra_q  <= bank_base(wr_bank_q) + wr_cnt_q;
                dina_q   <= cam_pix_data;
                wr_cnt_q <= wr_cnt_q + 1'b1;
              end else begin
                wr_ovf_q <= 1'b1;
              end
            end
            if (cam_frame_done) begin
              state_q <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase

      // A commit coinciding with the display edge bypasses straight to the reader.
      if (commit && disp_rise) begin
        rd_bank_q     <= wr_bank_q;
        ready_valid_q <= 1'b0;
      end else if (commit) begin
        ready_bank_q  <= wr_bank_q;
        ready_valid_q <= 1'b1;
      end else if (disp_rise && ready_valid_q) begin
        rd_bank_q     <= ready_bank_q;
        ready_valid_q <= 1'b0;
      end
    end
  end

  assign wea     = wea_q;
  assign addra   = addra_q;
  assign dina    = dina_q;
  assign addrb   = bank_base(rd_bank_q) + disp_addr;
  assign rd_bank = rd_bank_q;
  assign wr_bank = wr_bank_q;
  assign wr_ovf  = wr_ovf_q;

`ifdef FB_STATS_EN
  logic drop_inc, repeat_inc;

  assign drop_inc   = commit & ready_valid_q;
  assign repeat_inc = disp_rise & ~ready_valid_q & ~commit;

  fb_sat_counter #(.W(CNT_W)) u_drop_cnt (
    .clk     (CLK_25M),
    .rst_n   (RESETN),
    .inc_i   (drop_inc),
    .count_o (drop_cnt)
  );

  fb_sat_counter #(.W(CNT_W)) u_repeat_cnt (
    .clk     (CLK_25M),
    .rst_n   (RESETN),
    .inc_i   (repeat_inc),
    .count_o (repeat_cnt)
  );
`else
  assign drop_cnt   = '0;
  assign repeat_cnt = '0;
`endif

endmodule

// File: tb/tb_fb_bank_scheduler.sv
// Directed self-checking bench for fb_bank_scheduler; statistics expectations follow FB_STATS_EN.
module tb_fb_bank_scheduler;

  localparam int FW = 19200;
  localparam int AW = 16;
  localparam int CW = 8;
`ifdef FB_STATS_EN
  localparam int STATS = 1;
`else
  localparam int STATS = 0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cam_frame_start, cam_frame_done, cam_pix_valid;
  logic [15:0]   cam_pix_data;
  logic [AW-1:0] disp_addr;
  logic          disp_frame_end;
  logic          wea;
  logic [AW-1:0] addra, addrb;
  logic [15:0]   dina;
  logic [1:0]    rd_bank, wr_bank;
  logic          wr_ovf;
  logic [CW-1:0] drop_cnt, repeat_cnt;

  int checks = 0;
  int errors = 0;
  int n_wr, n_bad, ovf_at;

  fb_bank_scheduler #(.FRAME_WORDS(FW), .AW(AW), .CNT_W(CW)) dut (
    .CLK_25M         (clk),
    .RESETN          (rst_n),
    .cam_frame_start (cam_frame_start),
    .cam_frame_done  (cam_frame_done),
    .cam_pix_valid   (cam_pix_valid),
    .cam_pix_data    (cam_pix_data),
    .disp_addr       (disp_addr),
    .disp_frame_end  (disp_frame_end),
    .wea             (wea),
    .addra           (addra),
    .dina            (dina),
    .addrb           (addrb),
    .rd_bank         (rd_bank),
    .wr_bank         (wr_bank),
    .wr_ovf          (wr_ovf),
    .drop_cnt        (drop_cnt),
    .repeat_cnt      (repeat_cnt)
  );

  always #20 clk = ~clk;

  initial begin
    #10ms;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    cam_frame_start = 1'b0;
    cam_frame_done  = 1'b0;
    cam_pix_valid   = 1'b0;
    cam_pix_data    = '0;
    disp_frame_end  = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic pulse_start();
    cam_frame_start = 1'b1;
    tick();
    cam_frame_start = 1'b0;
  endtask

  task automatic pulse_done();
    cam_frame_done = 1'b1;
    tick();
    cam_frame_done = 1'b0;
  endtask

  // Streams n pixels; each observed write must land at base+k carrying pixel k.
  task automatic stream(input int n, input int base, output int writes, output int bad,
                        output int first_ovf);
    writes = 0;
    bad = 0;
    first_ovf = -1;
    for (int i = 0; i < n; i++) begin
      cam_pix_valid = 1'b1;
      cam_pix_data  = 16'(i * 7 + 3);
      tick();
      if (wea) begin
        if (addra !== AW'(base + writes) || dina !== 16'(writes * 7 + 3)) bad++;
        writes++;
      end
      if (wr_ovf && first_ovf < 0) first_ovf = i;
    end
    cam_pix_valid = 1'b0;
  endtask

  initial begin
    clear_inputs();
    disp_addr = 16'd123;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #3;
    check("rst_rd_bank", rd_bank, 0);
    check("rst_wr_bank", wr_bank, 1);
    check("rst_wea", wea, 0);
    check("rst_addra", addra, 0);
    check("rst_dina", dina, 0);
    check("rst_wr_ovf", wr_ovf, 0);
    check("rst_drop", drop_cnt, 0);
    check("rst_repeat", repeat_cnt, 0);
    check("rst_addrb", addrb, 123);
    do_reset();

    // Full frame into bank 1, then display swap.
    pulse_start();
    check("f1_wr_bank", wr_bank, 1);
    stream(FW, FW, n_wr, n_bad, ovf_at);
    check("f1_writes", n_wr, FW);
    check("f1_bad", n_bad, 0);
    check("f1_no_ovf", ovf_at, -1);
    tick();
    check("f1_wea_idle", wea, 0);
    pulse_done();
    check("f1_rd_before", rd_bank, 0);
    disp_frame_end = 1'b1;
    tick();
    check("f1_rd_after", rd_bank, 1);
    disp_addr = 16'd5;
    #1;
    check("f1_addrb", addrb, FW + 5);
    check("f1_repeat", repeat_cnt, 0);
    disp_frame_end = 1'b0;
    tick();

    // Two commits with no display edge: drop, bank rotation.
    do_reset();
    pulse_start();
    stream(4, FW, n_wr, n_bad, ovf_at);
    pulse_done();
    pulse_start();
    check("f2_wr_bank2", wr_bank, 2);
    stream(3, 2 * FW, n_wr, n_bad, ovf_at);
    check("f2_writes", n_wr, 3);
    check("f2_bad", n_bad, 0);
    pulse_done();
    check("f2_drop1", drop_cnt, STATS);
    pulse_start();
    check("f2_wr_bank1", wr_bank, 1);
    check("f2_rd_bank", rd_bank, 0);
    pulse_done();
    check("f2_drop2", drop_cnt, 2 * STATS);

    // Display edges with nothing ready.
    do_reset();
    for (int k = 1; k <= 2; k++) begin
      disp_frame_end = 1'b1;
      tick();
      check("f3_repeat", repeat_cnt, k * STATS);
      check("f3_rd_bank", rd_bank, 0);
      disp_frame_end = 1'b0;
      tick();
    end

    // Overlong frame.
    do_reset();
    pulse_start();
    stream(FW + 5, FW, n_wr, n_bad, ovf_at);
    check("f4_writes", n_wr, FW);
    check("f4_bad", n_bad, 0);
    check("f4_ovf_at", ovf_at, FW);
    check("f4_ovf_sticky", wr_ovf, 1);
    pulse_done();
    pulse_start();
    check("f4_ovf_clr", wr_ovf, 0);
    check("f4_wr_bank", wr_bank, 2);

    // Commit and display edge in the same cycle.
    do_reset();
    pulse_start();
    stream(3, FW, n_wr, n_bad, ovf_at);
    cam_frame_done = 1'b1;
    disp_frame_end = 1'b1;
    tick();
    cam_frame_done = 1'b0;
    check("f5_rd_bypass", rd_bank, 1);
    check("f5_drop", drop_cnt, 0);
    disp_frame_end = 1'b0;
    tick();
    pulse_start();
    check("f5_wr_bank0", wr_bank, 0);
    stream(2, 0, n_wr, n_bad, ovf_at);
    check("f5_bank0_bad", n_bad, 0);
    pulse_done();
    pulse_start();
    check("f5_wr_bank2", wr_bank, 2);
    stream(2, 2 * FW, n_wr, n_bad, ovf_at);
    cam_frame_done = 1'b1;
    disp_frame_end = 1'b1;
    tick();
    cam_frame_done = 1'b0;
    check("f5_rd_bypass2", rd_bank, 2);
    check("f5_drop2", drop_cnt, STATS);
    check("f5_repeat", repeat_cnt, 0);
    disp_frame_end = 1'b0;
    tick();

    // Reset asserted mid-frame.
    pulse_start();
    cam_pix_valid = 1'b1;
    tick();
    tick();
    check("f6_wea_pre", wea, 1);
    #10 rst_n = 1'b0;
    #1;
    check("f6_wea_rst", wea, 0);
    check("f6_rd_rst", rd_bank, 0);
    check("f6_wr_rst", wr_bank, 1);
    @(negedge clk);
    rst_n = 1'b1;
    stream(5, FW, n_wr, n_bad, ovf_at);
    check("f6_no_writes", n_wr, 0);
    pulse_start();
    stream(1, FW, n_wr, n_bad, ovf_at);
    check("f6_restart_wr", n_wr, 1);
    check("f6_restart_bad", n_bad, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fb_bank_scheduler.md
# fb_bank_scheduler

Triple-buffer scheduler for the RGB565 frame store between the camera capture path and the display generator. Allocates one of three BRAM banks to the camera writer and one to the display reader, and generates the bank-relative write and read addresses. Swaps the display bank only at display frame boundaries, so the display never reads a partially written frame.

## Interface
Parameters:
- FRAME_WORDS, 19200, words per frame (160x120, RGB565)
- AW, 16, BRAM address width; 3*FRAME_WORDS must be ≤ 2^AW
- CNT_W, 8, width of the statistics counters

Ports:
- CLK_25M  in  1  single system clock; all inputs are synchronous to it
- RESETN  in  1  asynchronous active-low reset
- cam_frame_start  in  1  one-cycle pulse, camera frame begins
- cam_frame_done  in  1  one-cycle pulse, camera frame complete
- cam_pix_valid  in  1  pixel strobe
- cam_pix_data  in  16  RGB565 pixel
- disp_addr  in  AW  frame-relative read address from the display generator
- disp_frame_end  in  1  level, high during vertical sync
- wea  out  1  BRAM port A write enable
- addra  out  AW  BRAM port A address
- dina  out  16  BRAM port A data
- addrb  out  AW  BRAM port B address
- rd_bank  out  2  bank currently displayed
- wr_bank  out  2  bank currently written
- wr_ovf  out  1  sticky: too many pixels in the current frame
- drop_cnt  out  CNT_W  completed frames overwritten before display
- repeat_cnt  out  CNT_W  display frames shown without a new bank

## Operation
- Writer FSM has two states: IDLE and WRITING.
  - IDLE → WRITING on cam_frame_start. At the transition: wr_cnt←0, wr_ovf←0, wr_bank←lowest index not equal to rd_bank and not equal to ready_bank (when ready_valid).
  - WRITING on cam_pix_valid: when wr_cnt < FRAME_WORDS, write the pixel and increment wr_cnt. Otherwise suppress the write and set wr_ovf.
  - WRITING on cam_frame_done: commit and go to IDLE. Commit sets ready_bank←wr_bank and ready_valid←1. If ready_valid was already 1, increment drop_cnt.
  - WRITING on cam_frame_start (no done received): abort the frame. Restart wr_cnt at 0 in the same bank. No commit.
  - In IDLE, cam_pix_valid and cam_frame_done are ignored.
  - A short frame (done before FRAME_WORDS pixels) is committed as-is.
- Reader: swap on the rising edge of disp_frame_end (registered edge detect).
  - If ready_valid is 1: rd_bank←ready_bank and ready_valid←0.
  - Otherwise: increment repeat_cnt.
- cam_frame_done and the disp_frame_end edge in the same cycle: the commit bypasses, so the swap takes the newly committed bank. The overwritten ready bank counts as a drop only if ready_valid was already 1.
- Invariant: wr_bank ≠ rd_bank, and wr_bank ≠ ready_bank while ready_valid. Three banks guarantee a free bank always exists.
- Address arithmetic: base(b) = b*FRAME_WORDS, computed with constants (no multiplier).
  - addra = base(wr_bank) + wr_cnt.
  - addrb = base(rd_bank) + disp_addr, truncated to AW.
  - disp_addr ≥ FRAME_WORDS is passed through unchecked.
- Counters saturate at 2^CNT_W−1.
- Reset values: rd_bank=0, wr_bank=1, ready_valid=0, FSM=IDLE, wr_cnt=0, wea=0, addra=0, dina=0, wr_ovf=0, drop_cnt=0, repeat_cnt=0. addrb follows disp_addr (base 0).

## Timing
- Write path: 1-cycle latency. cam_pix_valid at cycle n → wea/addra/dina registered at n+1.
- Read path: addrb is combinational from registered rd_bank and disp_addr, adding zero latency to the display pipeline.
- rd_bank changes in the cycle after the disp_frame_end rising edge, which falls within vertical blanking.
- wr_bank changes in the cycle after cam_frame_start.
- Reset asserted mid-frame: all state returns to reset values immediately. The next write begins only after a new cam_frame_start.

## Configuration
- FB_STATS_EN defined: drop_cnt and repeat_cnt are implemented as described.
- FB_STATS_EN undefined: both outputs are tied to 0 and no counter registers are instantiated. All other behaviour is identical.

## Structure
- Package fb_pkg contains:
  - FRAME_WORDS
  - the bank index type (2 bits)
  - the bank base-address constants BASE0/1/2
  - the writer state encoding (IDLE, WRITING)
- One sub-module, fb_sat_counter (width-parameterised, saturating increment, async active-low clear). It is instantiated twice, under FB_STATS_EN.

## Test plan
- Reset, one full frame (start, 19200 pixels, done), then a disp_frame_end rise → writes land at 19200..38399; rd_bank becomes 1; addrb = 19200 + disp_addr.
- Two complete camera frames with no display edge between them → drop_cnt=1; second frame written to bank 2, then bank 1 reused; rd_bank stays 0.
- disp_frame_end edges with no committed frame → repeat_cnt increments once per edge; rd_bank unchanged.
- 19205 pixels in one frame → exactly 19200 writes; wr_ovf=1 after pixel 19201; wr_ovf cleared by the next cam_frame_start.
- cam_frame_done and disp_frame_end rise in the same cycle → rd_bank equals the just-written bank the next cycle; drop_cnt unchanged.
- RESETN pulsed low mid-frame → wea=0 and rd_bank=0 immediately; pixels before the next cam_frame_start produce no writes.
